serial_digit_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor. It adds or subtracts two WIDTH-bit operands one DIGIT-bit slice per clock, using a registered carry between slices. It is the area-reduced, handshaked successor to the flat 4-bit ripple-carry adder, intended for datapaths where a full-width carry chain is too long or too large. It has a valid/ready interface on input and output so it can sit between pipeline stages.

---
 rtl/serial_digit_adder_pkg.sv | 19 +
 rtl/serial_digit_adder_if.sv | 26 ++
 rtl/serial_digit_adder_rca.sv | 21 ++
 rtl/serial_digit_adder.sv | 132 +++++++++++++
 tb/tb_serial_digit_adder.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/serial_digit_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int n_slices(input int width, input int digit);
      return width / digit;
   endfunction

   // Slice counter needs at least one bit even when a single slice covers the word.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_digit_adder_if.sv
// Operand/result handshake bundle for serial_digit_adder.
interface serial_digit_adder_if #(
   parameter int WIDTH = 16
);
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             i_carry_in;
   logic             i_sub;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_s;
   logic             o_carry_out;
   logic             o_overflow;

   modport slave (
      input  i_valid, i_a, i_b, i_carry_in, i_sub, i_ready,
      output o_ready, o_valid, o_s, o_carry_out, o_overflow
   );

   modport master (
      output i_valid, i_a, i_b, i_carry_in, i_sub, i_ready,
      input  o_ready, o_valid, o_s, o_carry_out, o_overflow
   );
endinterface

// File: rtl/serial_digit_adder_rca.sv
// Combinational DIGIT-bit ripple-carry adder built from full-adder cells.
module ripple_carry_adder_n #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] i_a,
   input  logic [DIGIT-1:0] i_b,
   input  logic             i_carry_in,
   output logic [DIGIT-1:0] o_s,
   output logic             o_carry_out
);
   logic [DIGIT:0] c;

   assign c[0] = i_carry_in;

   for (genvar k = 0; k < DIGIT; k++) begin : g_fa
      assign o_s[k]   = i_a[k] ^ i_b[k] ^ c[k];
      assign c[k+1]   = (i_a[k] & i_b[k]) | (c[k] & (i_a[k] ^ i_b[k]));
   end

   assign o_carry_out = c[DIGIT];
endmodule

// File: rtl/serial_digit_adder.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice per clock through a single
// ripple-carry slice, with valid/ready handshakes on operands and result.
module serial_digit_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic                i_clk,
   input  logic                i_reset,
   serial_digit_adder_if.slave bus
);
   // state | meaning
   // IDLE  | o_ready high, waiting for operands
   // RUN   | one slice per cycle, LSB slice first
   // DONE  | result held with o_valid high until i_ready

   localparam int N  = n_slices(WIDTH, DIGIT);
   localparam int IW = idx_width(N);
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic              carry_q, carry_d;
   logic [WIDTH-1:0]  s_q, s_d;
   logic              co_q, co_d;
   logic              ov_q, ov_d;
   logic              ready_q, ready_d;
   logic              valid_q, valid_d;

   logic [DIGIT-1:0]       sum_sl;
   logic                   c_sl;
   logic [WIDTH+DIGIT-1:0] s_shift;

   // Operands shift right each slice so the adder always sees bits [DIGIT-1:0];
   // the sum enters the result from the top, landing aligned after N slices.
   ripple_carry_adder_n #(.DIGIT(DIGIT)) u_rca (
      .i_a        (a_q[DIGIT-1:0]),
      .i_b        (b_q[DIGIT-1:0]),
      .i_carry_in (carry_q),
      .o_s        (sum_sl),
      .o_carry_out(c_sl)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      s_d     = s_q;
      co_d    = co_q;
      ov_d    = ov_q;
      ready_d = ready_q;
      valid_d = valid_q;
      s_shift = {sum_sl, s_q};

      case (state_q)
         IDLE: begin
            if (bus.i_valid) begin
               // Subtraction runs as A + ~B + !borrow_in.
               a_d     = bus.i_a;
               b_d     = bus.i_sub ? ~bus.i_b : bus.i_b;
               carry_d = bus.i_carry_in ^ bus.i_sub;
               idx_d   = '0;
               ready_d = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = c_sl;
            s_d     = s_shift[WIDTH+DIGIT-1:DIGIT];
            idx_d   = idx_q + IW'(1);
            if (idx_q == LAST) begin
               idx_d   = '0;
               co_d    = c_sl;
               ov_d    = (a_q[DIGIT-1] == b_q[DIGIT-1]) && (sum_sl[DIGIT-1] != a_q[DIGIT-1]);
               valid_d = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.i_ready) begin
               valid_d = 1'b0;
               ready_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         s_q     <= '0;
         co_q    <= 1'b0;
         ov_q    <= 1'b0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         s_q     <= s_d;
         co_q    <= co_d;
         ov_q    <= ov_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
      end
   end

   assign bus.o_ready     = ready_q;
   assign bus.o_valid     = valid_q;
   assign bus.o_s         = s_q;
   assign bus.o_carry_out = co_q;
   assign bus.o_overflow  = ov_q;
endmodule

// File: tb/tb_serial_digit_adder.sv
// Drives three builds (DIGIT=4, 16, 1) in lockstep and checks each against an
// integer-arithmetic reference for sum, carry/borrow, signed overflow and latency.
module tb_serial_digit_adder;
   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        d_valid = 1'b0;
   logic [15:0] d_a = '0;
   logic [15:0] d_b = '0;
   logic        d_cin = 1'b0;
   logic        d_sub = 1'b0;
   logic        d_rdy = 1'b0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_digit_adder_if #(.WIDTH(16)) if_a ();
   serial_digit_adder_if #(.WIDTH(16)) if_b ();
   serial_digit_adder_if #(.WIDTH(16)) if_c ();

   assign if_a.i_valid = d_valid;  assign if_b.i_valid = d_valid;  assign if_c.i_valid = d_valid;
   assign if_a.i_a = d_a;          assign if_b.i_a = d_a;          assign if_c.i_a = d_a;
   assign if_a.i_b = d_b;          assign if_b.i_b = d_b;          assign if_c.i_b = d_b;
   assign if_a.i_carry_in = d_cin; assign if_b.i_carry_in = d_cin; assign if_c.i_carry_in = d_cin;
   assign if_a.i_sub = d_sub;      assign if_b.i_sub = d_sub;      assign if_c.i_sub = d_sub;
   assign if_a.i_ready = d_rdy;    assign if_b.i_ready = d_rdy;    assign if_c.i_ready = d_rdy;

   serial_digit_adder #(.WIDTH(16), .DIGIT(4))  dut_d4  (.i_clk(clk), .i_reset(rst), .bus(if_a));
   serial_digit_adder #(.WIDTH(16), .DIGIT(16)) dut_d16 (.i_clk(clk), .i_reset(rst), .bus(if_b));
   serial_digit_adder #(.WIDTH(16), .DIGIT(1))  dut_d1  (.i_clk(clk), .i_reset(rst), .bus(if_c));

   logic [2:0]  vld, rdy_o, co_o, ov_o;
   logic [15:0] s_o [3];
   assign vld   = {if_c.o_valid, if_b.o_valid, if_a.o_valid};
   assign rdy_o = {if_c.o_ready, if_b.o_ready, if_a.o_ready};
   assign co_o  = {if_c.o_carry_out, if_b.o_carry_out, if_a.o_carry_out};
   assign ov_o  = {if_c.o_overflow, if_b.o_overflow, if_a.o_overflow};
   assign s_o[0] = if_a.o_s;
   assign s_o[1] = if_b.o_s;
   assign s_o[2] = if_c.o_s;

   int lat_exp [3] = '{4, 1, 16};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: {ov, co, s} from signed/unsigned integer arithmetic.
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic c, input logic sub);
      int ua = int'(a);
      int ub = int'(b);
      int sa = int'($signed(a));
      int sb = int'($signed(b));
      int ci = c ? 1 : 0;
      int r, sr;
      logic co, ov;
      if (!sub) begin
         r  = ua + ub + ci;
         sr = sa + sb + ci;
         co = (r > 65535);
      end else begin
         r  = ua - ub - ci;
         sr = sa - sb - ci;
         co = (r >= 0);
      end
      ov = (sr > 32767) || (sr < -32768);
      return {ov, co, r[15:0]};
   endfunction

   task automatic chk_result(input string tag, input logic [17:0] e);
      for (int d = 0; d < 3; d++) begin
         chk({tag, "_s"}, 32'(s_o[d]), 32'(e[15:0]));
         chk({tag, "_co"}, 32'(co_o[d]), 32'(e[16]));
         chk({tag, "_ov"}, 32'(ov_o[d]), 32'(e[17]));
      end
   endtask

   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        input logic ts, input int hold);
      logic [17:0] e;
      int lat [3];
      e = model(ta, tb, tc, ts);
      @(negedge clk);
      d_a = ta; d_b = tb; d_cin = tc; d_sub = ts; d_valid = 1'b1; d_rdy = 1'b0;
      @(posedge clk); #1;
      d_valid = 1'b0;
      chk("accept_ready", 32'(rdy_o), 32'h0);
      lat = '{0, 0, 0};
      for (int k = 1; k <= 40 && vld != 3'b111; k++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++) if (vld[d] && lat[d] == 0) lat[d] = k;
         chk("busy_ready", 32'(rdy_o), 32'h0);
         d_valid = 1'($urandom); d_a = 16'($urandom); d_b = 16'($urandom);
      end
      d_valid = 1'b0;
      for (int d = 0; d < 3; d++) chk("latency", 32'(lat[d]), 32'(lat_exp[d]));
      chk_result("res", e);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_valid", 32'(vld), 32'h7);
         chk("hold_ready", 32'(rdy_o), 32'h0);
         chk_result("hold", e);
         d_valid = 1'($urandom); d_a = 16'($urandom);
      end
      d_valid = 1'b0;
      d_rdy = 1'b1;
      @(posedge clk); #1;
      d_rdy = 1'b0;
      chk("ready_back", 32'(rdy_o), 32'h7);
      chk("valid_drop", 32'(vld), 32'h0);
   endtask

   initial begin
      #12;
      chk("rst_ready", 32'(rdy_o), 32'h7);
      chk("rst_valid", 32'(vld), 32'h0);
      chk("rst_s", 32'(s_o[0] | s_o[1] | s_o[2]), 32'h0);
      chk("rst_co_ov", 32'({co_o, ov_o}), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 3);
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
      do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1);
      do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
      do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
      do_op(16'h0000, 16'h0000, 1'b1, 1'b1, 0);

      // Reset partway through a run.
      @(negedge clk);
      d_a = 16'hABCD; d_b = 16'h1111; d_cin = 1'b0; d_sub = 1'b0; d_valid = 1'b1;
      @(posedge clk); #1;
      d_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(vld), 32'h0);
      chk("mid_rst_ready", 32'(rdy_o), 32'h7);
      chk("mid_rst_s", 32'(s_o[0] | s_o[1] | s_o[2]), 32'h0);
      chk("mid_rst_co_ov", 32'({co_o, ov_o}), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

      for (int i = 0; i < 1000; i++)
         do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
